// File: rtl/serial_in_capture.sv
// serial_in_capture: samples one serial line with a per-bit slow/fast period, then returns the
// captured word to the host as a UART packet: header, data bytes LSB first, XOR checksum.
module serial_in_capture #(
   parameter int unsigned DATA_BIT = 32,
   parameter int unsigned SLOW_DIV = 100,
   parameter int unsigned FAST_DIV = 10,
   parameter logic [7:0]  HEADER   = 8'hA5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_serial_in,
   input  logic                i_start,
   input  logic                i_stop,
   input  logic                i_mode,
   input  logic [DATA_BIT-1:0] i_freq_pattern,
   input  logic                i_tx_done_tick,
   output logic [7:0]          o_tx_data,
   output logic                o_tx_start,
   output logic [DATA_BIT-1:0] o_capture_data,
   output logic                o_bit_tick,
   output logic                o_done_tick,
   output logic                o_busy
);

   localparam int unsigned MaxDiv = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
   localparam int unsigned CntW   = $clog2(MaxDiv);
   localparam int unsigned IdxW   = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
   localparam int unsigned NBytes = DATA_BIT / 8;
   localparam int unsigned PktLen = NBytes + 2;
   localparam int unsigned ByteW  = $clog2(PktLen);

   localparam logic [CntW-1:0] SlowLast = CntW'(SLOW_DIV - 1);
   localparam logic [CntW-1:0] SlowHalf = CntW'(SLOW_DIV / 2);
   localparam logic [CntW-1:0] FastLast = CntW'(FAST_DIV - 1);
   localparam logic [CntW-1:0] FastHalf = CntW'(FAST_DIV / 2);

   typedef enum logic [2:0] {
      StIdle,
      StCapture,
      StLoad,
      StSend,
      StWait,
      StDone
   } state_t;

   state_t                  state_q, state_d;
   logic                    mode_q;
   logic [DATA_BIT-1:0]     freq_q;
   logic [IdxW-1:0]         idx_q;
   logic [CntW-1:0]         cnt_q;
   logic [DATA_BIT-1:0]     shift_q;
   logic [DATA_BIT-1:0]     capture_q;
   logic [PktLen*8-1:0]     pkt_q;
   logic [ByteW-1:0]        byte_q;
   logic                    stop_pend_q;

   logic                    fast_bit;
   logic [CntW-1:0]         cnt_last;
   logic [CntW-1:0]         cnt_half;
   logic                    bit_end;
   logic                    last_bit;
   logic                    last_byte;
   logic [7:0]              chk;

   assign fast_bit  = freq_q[idx_q];
   assign cnt_last  = fast_bit ? FastLast : SlowLast;
   assign cnt_half  = fast_bit ? FastHalf : SlowHalf;
   assign bit_end   = (state_q == StCapture) && (cnt_q == cnt_last);
   assign last_bit  = (idx_q == IdxW'(DATA_BIT - 1));
   assign last_byte = (byte_q == ByteW'(PktLen - 1));

   always_comb begin
      chk = '0;
      for (int i = 0; i < int'(NBytes); i++) begin
         chk ^= shift_q[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (i_start && !i_stop) state_d = StCapture;
         end
         StCapture: begin
            if (i_stop)                    state_d = StIdle;
            else if (bit_end && last_bit)  state_d = StLoad;
         end
         StLoad: state_d = StSend;
         StSend: state_d = StWait;
         StWait: begin
            if (i_tx_done_tick) state_d = last_byte ? StDone : StSend;
         end
         StDone: begin
            state_d = (mode_q && !stop_pend_q && !i_stop) ? StCapture : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      o_tx_start     = (state_q == StSend);
      o_done_tick    = (state_q == StDone);
      o_busy         = (state_q != StIdle);
      o_bit_tick     = bit_end;
      o_tx_data      = pkt_q[{byte_q, 3'b000} +: 8];
      o_capture_data = capture_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode_q      <= 1'b0;
         freq_q      <= '0;
         idx_q       <= '0;
         cnt_q       <= '0;
         shift_q     <= '0;
         capture_q   <= '0;
         pkt_q       <= '0;
         byte_q      <= '0;
         stop_pend_q <= 1'b0;
      end else begin
         if (state_q == StIdle && state_d == StCapture) begin
            mode_q <= i_mode;
            freq_q <= i_freq_pattern;
         end

         // Fresh capture (from idle or a repeat pass) always restarts at bit 0, count 0.
         if (state_q != StCapture && state_d == StCapture) begin
            idx_q <= '0;
            cnt_q <= '0;
         end else if (state_q == StCapture) begin
            if (cnt_q == cnt_half) shift_q[idx_q] <= i_serial_in;
            if (bit_end) begin
               cnt_q <= '0;
               idx_q <= idx_q + IdxW'(1);
            end else begin
               cnt_q <= cnt_q + CntW'(1);
            end
         end

         if (state_q == StLoad) begin
            capture_q <= shift_q;
            pkt_q     <= {chk, shift_q, HEADER};
            byte_q    <= '0;
         end else if (state_q == StWait && i_tx_done_tick && !last_byte) begin
            byte_q <= byte_q + ByteW'(1);
         end

         // A stop after capture finishes lets the packet complete, then forces idle.
         if (state_d == StIdle) begin
            stop_pend_q <= 1'b0;
         end else if (i_stop && (state_q == StLoad || state_q == StSend || state_q == StWait)) begin
            stop_pend_q <= 1'b1;
         end
      end
   end

endmodule
